// File: rtl/snake_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared phase encoding and default widths for the snake game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    localparam int SCORE_BIT_DEF = 8;
    localparam int LEVEL_BIT_DEF = 3;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_RUN   = 3'd2,
        PH_OVER  = 3'd3,
        PH_PAUSE = 3'd4
    } phase_e;

endpackage

`default_nettype wire

// File: rtl/game_phase_controller_if.sv
// ============================================================================
// Module      : game_phase_controller_if
// Description : Link between the phase controller and the snake FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_phase_controller_if;

    logic move_tik;
    logic soft_reset_n;
    logic fruit_eaten;
    logic collision;

    modport master (
        output move_tik,
        output soft_reset_n,
        input  fruit_eaten,
        input  collision
    );

    modport slave (
        input  move_tik,
        input  soft_reset_n,
        output fruit_eaten,
        output collision
    );

endinterface

`default_nettype wire

// File: rtl/button_edge.sv
// ============================================================================
// Module      : button_edge
// Description : Two-flop synchroniser with a registered rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_edge (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn,
    output logic      o_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/game_phase_controller.sv
// ============================================================================
// Module      : game_phase_controller
// Description : IDLE/INIT/RUN/OVER game sequencer with score, high score and
//               level-scaled move_tik. Optional macro PAUSE_EN adds PAUSE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_phase_controller
    import snake_pkg::*;
#(
    parameter int SCORE_BIT        = SCORE_BIT_DEF,
    parameter int LEVEL_BIT        = LEVEL_BIT_DEF,
    parameter int BASE_DIV         = 8,
    parameter int FRUITS_PER_LEVEL = 4,
    parameter int OVER_FRAMES      = 60
) (
    input  wire logic                 clock_25,
    input  wire logic                 reset,
    input  wire logic                 frame_tik,
    input  wire logic                 game_tik,
    input  wire logic                 start_P,
    game_phase_controller_if.master   snake_if,
    output logic                      game_enable,
    output logic [2:0]                phase,
    output logic [SCORE_BIT-1:0]      score,
    output logic [SCORE_BIT-1:0]      high_score,
    output logic [LEVEL_BIT-1:0]      speed_level
);

    localparam int DIV_W   = $clog2(BASE_DIV + 1);
    localparam int FRUIT_W = (FRUITS_PER_LEVEL > 1) ? $clog2(FRUITS_PER_LEVEL) : 1;
    localparam int OVER_W  = $clog2(OVER_FRAMES + 1);

    localparam logic [FRUIT_W-1:0] C_FRUIT_LAST = FRUIT_W'(FRUITS_PER_LEVEL - 1);
    localparam logic [OVER_W-1:0]  C_OVER_MAX   = OVER_W'(OVER_FRAMES);

    phase_e               phase_q,       phase_d;
    logic [SCORE_BIT-1:0] score_q,       score_d;
    logic [SCORE_BIT-1:0] high_score_q,  high_score_d;
    logic [LEVEL_BIT-1:0] speed_level_q, speed_level_d;
    logic [DIV_W-1:0]     tik_cnt_q,     tik_cnt_d;
    logic [FRUIT_W-1:0]   fruit_cnt_q,   fruit_cnt_d;
    logic [OVER_W-1:0]    over_cnt_q,    over_cnt_d;
    logic                 move_tik_q,    move_tik_d;
    logic                 soft_rst_n_q,  soft_rst_n_d;
    logic                 game_en_q,     game_en_d;

    logic             w_start_edge;
    logic             w_pause_req;
    logic             w_enter_init;
    logic [DIV_W-1:0] w_div_m1;

    button_edge u_start_edge (
        .clk     (clock_25),
        .rst_n   (reset),
        .i_btn   (start_P),
        .o_pulse (w_start_edge)
    );

`ifdef PAUSE_EN
    assign w_pause_req = w_start_edge;
`else
    assign w_pause_req = 1'b0;
`endif

    // Terminal count is div-1 with div = BASE_DIV - level, floored at 1.
    always_comb begin
        w_div_m1 = '0;
        if (32'(speed_level_q) < 32'(BASE_DIV - 1))
            w_div_m1 = DIV_W'(32'(BASE_DIV - 1) - 32'(speed_level_q));
    end

    always_comb begin
        phase_d       = phase_q;
        score_d       = score_q;
        high_score_d  = high_score_q;
        speed_level_d = speed_level_q;
        tik_cnt_d     = tik_cnt_q;
        fruit_cnt_d   = fruit_cnt_q;
        over_cnt_d    = over_cnt_q;
        move_tik_d    = 1'b0;
        soft_rst_n_d  = 1'b1;
        w_enter_init  = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (w_start_edge)
                    w_enter_init = 1'b1;
            end
            PH_INIT: begin
                if (frame_tik)
                    phase_d = PH_RUN;
            end
            PH_RUN: begin
                // Collision wins over any move or fruit on the same cycle.
                if (snake_if.collision) begin
                    phase_d    = PH_OVER;
                    over_cnt_d = '0;
                    if (score_q > high_score_q)
                        high_score_d = score_q;
                end else begin
                    if (w_pause_req) begin
                        phase_d = PH_PAUSE;
                    end else if (game_tik) begin
                        if (tik_cnt_q >= w_div_m1) begin
                            tik_cnt_d  = '0;
                            move_tik_d = 1'b1;
                        end else begin
                            tik_cnt_d = tik_cnt_q + 1'b1;
                        end
                    end
                    if (snake_if.fruit_eaten) begin
                        if (score_q != '1)
                            score_d = score_q + 1'b1;
                        if (fruit_cnt_q == C_FRUIT_LAST) begin
                            fruit_cnt_d = '0;
                            if (speed_level_q != '1)
                                speed_level_d = speed_level_q + 1'b1;
                        end else begin
                            fruit_cnt_d = fruit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            PH_PAUSE: begin
                if (w_pause_req)
                    phase_d = PH_RUN;
            end
            PH_OVER: begin
                if (frame_tik && (over_cnt_q != C_OVER_MAX))
                    over_cnt_d = over_cnt_q + 1'b1;
                if (w_start_edge && (over_cnt_q == C_OVER_MAX))
                    w_enter_init = 1'b1;
            end
            default: phase_d = PH_IDLE;
        endcase

        if (w_enter_init) begin
            phase_d       = PH_INIT;
            soft_rst_n_d  = 1'b0;
            score_d       = '0;
            speed_level_d = '0;
            tik_cnt_d     = '0;
            fruit_cnt_d   = '0;
        end

        game_en_d = (phase_d == PH_RUN) || (phase_d == PH_PAUSE);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            phase_q       <= PH_IDLE;
            score_q       <= '0;
            high_score_q  <= '0;
            speed_level_q <= '0;
            tik_cnt_q     <= '0;
            fruit_cnt_q   <= '0;
            over_cnt_q    <= '0;
            move_tik_q    <= 1'b0;
            soft_rst_n_q  <= 1'b1;
            game_en_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            score_q       <= score_d;
            high_score_q  <= high_score_d;
            speed_level_q <= speed_level_d;
            tik_cnt_q     <= tik_cnt_d;
            fruit_cnt_q   <= fruit_cnt_d;
            over_cnt_q    <= over_cnt_d;
            move_tik_q    <= move_tik_d;
            soft_rst_n_q  <= soft_rst_n_d;
            game_en_q     <= game_en_d;
        end
    end

    assign snake_if.move_tik     = move_tik_q;
    assign snake_if.soft_reset_n = soft_rst_n_q;
    assign game_enable           = game_en_q;
    assign phase                 = phase_q;
    assign score                 = score_q;
    assign high_score            = high_score_q;
    assign speed_level           = speed_level_q;

endmodule

`default_nettype wire
